// File: rtl/fre_pkg.sv
// Shared widths and enumerations for the fre_gen frequency/pulse generator.
package fre_pkg;

    localparam int FRE_W    = 22;
    localparam int FRE_PW_W = 16;

    typedef enum logic {
        MODE_SQ    = 1'b0,
        MODE_PULSE = 1'b1
    } fre_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fre_state_e;

endpackage

// File: rtl/fre_div_cnt.sv
// Wrapping period counter: counts 0..n_cur-1, held at 0 while load is high.
module fre_div_cnt
    import fre_pkg::*;
#(
    parameter int W = FRE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] n_cur,
    output logic [W-1:0] cnt_nxt,
    output logic         wrap
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;

    assign wrap = (cnt == n_cur - ONE);

    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = '0;
        end else if (inc) begin
            cnt_nxt = wrap ? '0 : cnt + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/fre_gen.sv
// Programmable square/pulse generator with a period of N clk cycles and
// double-buffered settings that only change at a period boundary.
module fre_gen
    import fre_pkg::*;
#(
    parameter int W    = FRE_W,
    parameter int PW_W = FRE_PW_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            n_load,
    input  logic [W-1:0]    n_in,
    input  logic            mode,
    input  logic [PW_W-1:0] pw,
    output logic            n_ack,
    output logic            n_err,
    output logic            freq_out,
    output logic            period_tick,
    output logic            active
);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] TWO = W'(2);

    fre_state_e      state, state_nxt;
    logic [W-1:0]    n_pend, n_cur;
    fre_mode_e       mode_pend, mode_cur;
    logic [PW_W-1:0] pw_pend, pw_cur;
    logic            pend, valid;

    logic            load_ok, boundary, apply;
    logic [W-1:0]    cnt_nxt;
    logic            wrap;
    logic [W-1:0]    n_use, half_hi, pw_ext, pw_thr;
    fre_mode_e       mode_use;
    logic [PW_W-1:0] pw_use;
    logic            wave_hi;

    fre_div_cnt #(.W(W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state == ST_IDLE),
        .inc     (state != ST_IDLE),
        .n_cur   (n_cur),
        .cnt_nxt (cnt_nxt),
        .wrap    (wrap)
    );

    assign load_ok     = n_load && (n_in >= TWO);
    assign boundary    = (state != ST_IDLE) && wrap;
    assign apply       = pend && (boundary || ((state == ST_IDLE) && en && valid));
    assign period_tick = boundary;
    assign active      = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (en && valid) state_nxt = ST_RUN;
            ST_RUN:   if (!en) state_nxt = wrap ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end else if (wrap) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The waveform is judged against the set that will be active next cycle.
    always_comb begin
        n_use    = apply ? n_pend    : n_cur;
        mode_use = apply ? mode_pend : mode_cur;
        pw_use   = apply ? pw_pend   : pw_cur;
        half_hi  = n_use - (n_use >> 1);
        pw_ext   = W'(pw_use);
        pw_thr   = pw_ext;
        if (pw_ext == '0) begin
            pw_thr = ONE;
        end else if (pw_ext > n_use - ONE) begin
            pw_thr = n_use - ONE;
        end
        wave_hi = (mode_use == MODE_SQ) ? (cnt_nxt < half_hi) : (cnt_nxt < pw_thr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_pend    <= '0;
            mode_pend <= MODE_SQ;
            pw_pend   <= '0;
            pend      <= 1'b0;
            valid     <= 1'b0;
            n_cur     <= '0;
            mode_cur  <= MODE_SQ;
            pw_cur    <= '0;
            n_ack     <= 1'b0;
            n_err     <= 1'b0;
            freq_out  <= 1'b0;
        end else begin
            n_ack    <= load_ok;
            n_err    <= n_load && !load_ok;
            freq_out <= (state_nxt != ST_IDLE) && wave_hi;
            if (load_ok) begin
                n_pend    <= n_in;
                mode_pend <= fre_mode_e'(mode);
                pw_pend   <= pw;
                valid     <= 1'b1;
            end
            // A load on the apply edge stays pending for the following boundary.
            if (load_ok) begin
                pend <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
            if (apply) begin
                n_cur    <= n_pend;
                mode_cur <= mode_pend;
                pw_cur   <= pw_pend;
            end
        end
    end

endmodule

// File: tb/tb_fre_gen.sv
// Scoreboard bench for fre_gen: a period/position model predicts every cycle's
// outputs, a separate monitor pops and compares them one cycle later.
module tb_fre_gen;
    import fre_pkg::*;

    localparam int W    = FRE_W;
    localparam int PW_W = FRE_PW_W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            n_load = 1'b0;
    logic [W-1:0]    n_in = '0;
    logic            mode = 1'b0;
    logic [PW_W-1:0] pw = '0;
    logic            n_ack, n_err, freq_out, period_tick, active;

    fre_gen #(.W(W), .PW_W(PW_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .n_load      (n_load),
        .n_in        (n_in),
        .mode        (mode),
        .pw          (pw),
        .n_ack       (n_ack),
        .n_err       (n_err),
        .freq_out    (freq_out),
        .period_tick (period_tick),
        .active      (active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic freq;
        logic tick;
        logic act;
        logic ack;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: running flag, position within period, live and shadow settings.
    bit          m_run, m_valid, m_pend, m_mode, s_mode;
    int unsigned m_pos, m_n, m_pw, s_n, s_pw;

    function automatic bit modelHigh();
        int unsigned thr;
        if (!m_run) return 1'b0;
        if (!m_mode) return m_pos < (m_n + 1) / 2;
        if (m_pw == 0) thr = 1;
        else if (m_pw > m_n - 1) thr = m_n - 1;
        else thr = m_pw;
        return m_pos < thr;
    endfunction

    task automatic takePending();
        if (m_pend) begin
            m_n    = s_n;
            m_mode = s_mode;
            m_pw   = s_pw;
            m_pend = 1'b0;
        end
    endtask

    task automatic modelStep(input bit e, input bit ld, input int unsigned nin,
                             input bit md, input int unsigned p, output exp_t x);
        x     = '0;
        x.ack = ld && (nin >= 2);
        x.err = ld && (nin < 2);
        if (!m_run) begin
            if (e && m_valid) begin
                takePending();
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos == m_n - 1) begin
            takePending();
            m_pos = 0;
            if (!e) m_run = 1'b0;
        end else begin
            m_pos++;
        end
        if (ld && nin >= 2) begin
            s_n     = nin;
            s_mode  = md;
            s_pw    = p;
            m_pend  = 1'b1;
            m_valid = 1'b1;
        end
        x.act  = m_run;
        x.tick = m_run && (m_pos == m_n - 1);
        x.freq = modelHigh();
    endtask

    task automatic checkOutput(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input bit e, input bit ld, input int unsigned nin,
                                 input bit md, input int unsigned p);
        exp_t x;
        @(negedge clk);
        rst_n  = 1'b1;
        en     = e;
        n_load = ld;
        n_in   = W'(nin);
        mode   = md;
        pw     = PW_W'(p);
        modelStep(e, ld, nin, md, p, x);
        exp_q.push_back(x);
    endtask

    task automatic runCycles(input int n, input bit e);
        for (int i = 0; i < n; i++) applyStimulus(e, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic runUntilPos(input int unsigned pos);
        for (int i = 0; i < 64 && m_pos != pos; i++) runCycles(1, 1'b1);
    endtask

    // Asserts reset between edges and checks the asynchronous clear at once.
    task automatic doReset();
        @(negedge clk);
        rst_n  = 1'b0;
        en     = 1'b0;
        n_load = 1'b0;
        m_run = 0; m_valid = 0; m_pend = 0; m_mode = 0; s_mode = 0;
        m_pos = 0; m_n = 0; m_pw = 0; s_n = 0; s_pw = 0;
        #1;
        checkOutput("rst_freq_out", freq_out, 1'b0);
        checkOutput("rst_period_tick", period_tick, 1'b0);
        checkOutput("rst_active", active, 1'b0);
        checkOutput("rst_n_ack", n_ack, 1'b0);
        checkOutput("rst_n_err", n_err, 1'b0);
        exp_q.push_back('0);
        @(negedge clk);
        exp_q.push_back('0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checkOutput("freq_out", freq_out, x.freq);
                checkOutput("period_tick", period_tick, x.tick);
                checkOutput("active", active, x.act);
                checkOutput("n_ack", n_ack, x.ack);
                checkOutput("n_err", n_err, x.err);
            end
        end
    end

    initial begin : driver
        bit e_rand;
        doReset();
        runCycles(5, 1'b1);
        applyStimulus(1'b0, 1'b1, 1, 1'b0, 0);
        runCycles(3, 1'b1);
        applyStimulus(1'b0, 1'b1, 10, 1'b0, 0);
        runCycles(32, 1'b1);
        applyStimulus(1'b1, 1'b1, 7, 1'b0, 0);
        runCycles(25, 1'b1);
        applyStimulus(1'b1, 1'b1, 20, 1'b1, 3);
        runCycles(45, 1'b1);
        applyStimulus(1'b1, 1'b1, 20, 1'b1, 0);
        runCycles(45, 1'b1);
        applyStimulus(1'b1, 1'b1, 20, 1'b1, 50);
        runCycles(45, 1'b1);
        applyStimulus(1'b1, 1'b1, 10, 1'b0, 0);
        runCycles(25, 1'b1);
        runUntilPos(3);
        applyStimulus(1'b1, 1'b1, 4, 1'b0, 0);
        runCycles(2, 1'b1);
        applyStimulus(1'b1, 1'b1, 6, 1'b0, 0);
        runCycles(20, 1'b1);
        applyStimulus(1'b1, 1'b1, 10, 1'b0, 0);
        runCycles(12, 1'b1);
        runUntilPos(m_n - 1);
        applyStimulus(1'b1, 1'b1, 6, 1'b0, 0);
        runCycles(30, 1'b1);
        applyStimulus(1'b1, 1'b1, 10, 1'b0, 0);
        runCycles(15, 1'b1);
        runUntilPos(2);
        runCycles(15, 1'b0);
        runCycles(12, 1'b1);
        runUntilPos(2);
        runCycles(3, 1'b0);
        runCycles(20, 1'b1);
        runUntilPos(4);
        doReset();
        runCycles(6, 1'b1);

        e_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                doReset();
            end else begin
                if ($urandom_range(0, 14) == 0) e_rand = !e_rand;
                if ($urandom_range(0, 11) == 0)
                    applyStimulus(e_rand, 1'b1, $urandom_range(0, 12),
                                  1'($urandom_range(0, 1)), $urandom_range(0, 15));
                else
                    applyStimulus(e_rand, 1'b0, $urandom_range(0, 12),
                                  1'($urandom_range(0, 1)), $urandom_range(0, 15));
            end
        end

        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
